// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game controller: pipe collision/fall detection, scoring,
// lives with respawn countdown, pause and retained high score.
module flappy_game_ctrl #(
   parameter int COORD_W       = 10,
   parameter int NUM_PIPES     = 4,
   parameter int BIRD_HALF     = 10,
   parameter int PIPE_HALF_W   = 50,
   parameter int GAP_H         = 100,
   parameter int FLOOR_Y       = 470,
   parameter int SCORE_W       = 16,
   parameter int LIVES         = 3,
   parameter int RESPAWN_TICKS = 60
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           Start,
   input  logic                           Ack,
   input  logic                           Pause,
   input  logic                           Tick,
   input  logic [COORD_W-1:0]             XBird,
   input  logic [COORD_W-1:0]             YBird,
   input  logic [NUM_PIPES*COORD_W-1:0]   XPipes,
   input  logic [NUM_PIPES*COORD_W-1:0]   YPipes,
   output logic                           q_I,
   output logic                           q_Run,
   output logic                           q_Pause,
   output logic                           q_Hit,
   output logic                           q_End,
   output logic [SCORE_W-1:0]             Score,
   output logic [SCORE_W-1:0]             HighScore,
   output logic [$clog2(LIVES+1)-1:0]     LivesLeft,
   output logic                           NewHigh
);

   localparam int CW    = COORD_W + 2;
   localparam int LW    = $clog2(LIVES + 1);
   localparam int NW    = $clog2(NUM_PIPES + 1);
   localparam int CNT_W = $clog2(RESPAWN_TICKS + 2);

   localparam logic [CW-1:0] BH    = CW'(BIRD_HALF);
   localparam logic [CW-1:0] PHW   = CW'(PIPE_HALF_W);
   localparam logic [CW-1:0] GAP   = CW'(GAP_H);
   localparam logic [CW-1:0] FLOOR = CW'(FLOOR_Y);

   typedef enum logic [4:0] {
      S_INIT  = 5'b10000,
      S_RUN   = 5'b01000,
      S_PAUSE = 5'b00100,
      S_HIT   = 5'b00010,
      S_END   = 5'b00001
   } state_t;

   state_t                 state, state_d;
   logic [SCORE_W-1:0]     score, score_d, high, high_d;
   logic [LW-1:0]          lives, lives_d;
   logic                   nh, nh_d;
   logic [NUM_PIPES-1:0]   passed, passed_d;
   logic [CNT_W-1:0]       cnt, cnt_d;

   logic [CW-1:0]          xb, yb;
   logic [NUM_PIPES-1:0]   hit_p, pass_p, new_p;
   logic                   collide, fall;
   logic [NW-1:0]          n_new;
   logic [SCORE_W:0]       sum;
   logic [SCORE_W-1:0]     score_sat;

   assign xb = CW'(XBird);
   assign yb = CW'(YBird);

   // Inequalities are rearranged so only additions occur; nothing underflows.
   for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
      logic [CW-1:0] xp, yp;
      logic          x_ov, in_gap;
      assign xp        = CW'(XPipes[i*COORD_W +: COORD_W]);
      assign yp        = CW'(YPipes[i*COORD_W +: COORD_W]);
      assign x_ov      = (xb + BH + PHW >= xp) && (xb <= xp + PHW + BH);
      assign in_gap    = (yb >= yp + BH) && (yb + BH <= yp + GAP);
      assign hit_p[i]  = x_ov && !in_gap;
      assign pass_p[i] = xb > xp + PHW + BH;
   end

   assign collide = |hit_p;
   assign fall    = (yb + BH >= FLOOR);
   assign new_p   = pass_p & ~passed;

   always_comb begin
      n_new = '0;
      for (int i = 0; i < NUM_PIPES; i++)
         n_new = n_new + NW'(new_p[i]);
   end

   assign sum       = {1'b0, score} + (SCORE_W+1)'(n_new);
   assign score_sat = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state  <= S_INIT;
         score  <= '0;
         high   <= '0;
         lives  <= LW'(LIVES);
         nh     <= 1'b0;
         passed <= '0;
         cnt    <= '0;
      end else begin
         state  <= state_d;
         score  <= score_d;
         high   <= high_d;
         lives  <= lives_d;
         nh     <= nh_d;
         passed <= passed_d;
         cnt    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state;
      score_d  = score;
      high_d   = high;
      lives_d  = lives;
      nh_d     = nh;
      passed_d = passed;
      cnt_d    = cnt;
      unique case (state)
         S_INIT: begin
            score_d = '0;
            lives_d = LW'(LIVES);
            nh_d    = 1'b0;
            if (Start) begin
               state_d  = S_RUN;
               passed_d = pass_p;
            end
         end
         S_RUN: begin
            if (Pause) begin
               state_d = S_PAUSE;
            end else if (Tick) begin
               if (collide || fall) begin
                  lives_d = lives - LW'(1);
                  if (lives_d == '0) begin
                     state_d = S_END;
                     if (score > high) begin
                        high_d = score;
                        nh_d   = 1'b1;
                     end
                  end else begin
                     state_d = S_HIT;
                     cnt_d   = CNT_W'(RESPAWN_TICKS);
                  end
               end else begin
                  score_d  = score_sat;
                  passed_d = pass_p;
               end
            end
         end
         S_PAUSE: begin
            if (Pause)
               state_d = S_RUN;
         end
         S_HIT: begin
            if (Tick) begin
               if (cnt <= CNT_W'(1)) begin
                  cnt_d    = '0;
                  state_d  = S_RUN;
                  passed_d = pass_p;
               end else begin
                  cnt_d = cnt - CNT_W'(1);
               end
            end
         end
         S_END: begin
            if (Ack) begin
               state_d = S_INIT;
               score_d = '0;
               lives_d = LW'(LIVES);
               nh_d    = 1'b0;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   assign q_I       = state[4];
   assign q_Run     = state[3];
   assign q_Pause   = state[2];
   assign q_Hit     = state[1];
   assign q_End     = state[0];
   assign Score     = score;
   assign HighScore = high;
   assign LivesLeft = lives;
   assign NewHigh   = nh;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: vector table plus multi-cycle
// sequences for respawn, game over, async reset and score saturation.
module tb_flappy_game_ctrl;

   localparam logic [4:0] QI = 5'b10000;
   localparam logic [4:0] QR = 5'b01000;
   localparam logic [4:0] QP = 5'b00100;
   localparam logic [4:0] QH = 5'b00010;
   localparam logic [4:0] QE = 5'b00001;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Start, Ack, Pause, Tick;
   logic [9:0]  XBird, YBird;
   logic [39:0] XPipes, YPipes;
   logic        q_I, q_Run, q_Pause, q_Hit, q_End;
   logic [15:0] Score, HighScore;
   logic [1:0]  LivesLeft;
   logic        NewHigh;

   logic        s_I, s_Run, s_Pause, s_Hit, s_End, s_nh;
   logic [3:0]  s_score, s_high;
   logic [1:0]  s_lives;

   int checks   = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   flappy_game_ctrl dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
      .Pause(Pause), .Tick(Tick), .XBird(XBird), .YBird(YBird),
      .XPipes(XPipes), .YPipes(YPipes),
      .q_I(q_I), .q_Run(q_Run), .q_Pause(q_Pause), .q_Hit(q_Hit),
      .q_End(q_End), .Score(Score), .HighScore(HighScore),
      .LivesLeft(LivesLeft), .NewHigh(NewHigh)
   );

   flappy_game_ctrl #(.SCORE_W(4)) u_sat (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
      .Pause(Pause), .Tick(Tick), .XBird(XBird), .YBird(YBird),
      .XPipes(XPipes), .YPipes(YPipes),
      .q_I(s_I), .q_Run(s_Run), .q_Pause(s_Pause), .q_Hit(s_Hit),
      .q_End(s_End), .Score(s_score), .HighScore(s_high),
      .LivesLeft(s_lives), .NewHigh(s_nh)
   );

   typedef struct {
      logic        st, ak, pa, tk;
      logic [9:0]  xb, yb;
      logic [39:0] xp;
      logic [4:0]  q;
      logic [15:0] sc;
      logic [1:0]  lv;
   } vec_t;

   vec_t tbl[14];
   logic [39:0] P1, P2, P4;

   function automatic logic [39:0] pk(logic [9:0] a, logic [9:0] b,
                                      logic [9:0] c, logic [9:0] d);
      return {d, c, b, a};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all(logic [4:0] q, logic [15:0] sc, logic [15:0] hs,
                          logic [1:0] lv, logic nh);
      chk("state", 32'({q_I, q_Run, q_Pause, q_Hit, q_End}), 32'(q));
      chk("score", 32'(Score), 32'(sc));
      chk("high", 32'(HighScore), 32'(hs));
      chk("lives", 32'(LivesLeft), 32'(lv));
      chk("newhigh", 32'(NewHigh), 32'(nh));
   endtask

   task automatic step(logic st, logic ak, logic pa, logic tk,
                       logic [9:0] xb, logic [9:0] yb, logic [39:0] xp,
                       logic [4:0] q, logic [15:0] sc, logic [15:0] hs,
                       logic [1:0] lv, logic nh);
      Start = st; Ack = ak; Pause = pa; Tick = tk;
      XBird = xb; YBird = yb; XPipes = xp;
      @(posedge Clk);
      #1;
      chk_all(q, sc, hs, lv, nh);
   endtask

   // Fall, 59 ignored ticks (still falling), then resume on the 60th.
   task automatic respawn(logic [15:0] sc, logic [15:0] hs,
                          logic [1:0] lv, logic [39:0] xp);
      step(0, 0, 0, 1, 10'd300, 10'd465, xp, QH, sc, hs, lv, 1'b0);
      for (int i = 1; i < 60; i++)
         step(0, 0, 0, 1, 10'd300, 10'd465, xp, QH, sc, hs, lv, 1'b0);
      step(0, 0, 0, 1, 10'd300, 10'd200, xp, QR, sc, hs, lv, 1'b0);
   endtask

   initial begin
      P1 = pk(10'd200, 10'd900, 10'd900, 10'd900);
      P2 = pk(10'd200, 10'd205, 10'd900, 10'd900);
      P4 = pk(10'd200, 10'd200, 10'd200, 10'd200);
      YPipes = pk(10'd150, 10'd150, 10'd150, 10'd150);
      Reset = 1'b1;
      Start = 0; Ack = 0; Pause = 0; Tick = 0;
      XBird = 10'd100; YBird = 10'd200; XPipes = P1;

      tbl[0]  = '{0,0,0,0, 10'd100, 10'd200, P1, QI, 16'd0, 2'd3};
      tbl[1]  = '{1,0,0,0, 10'd100, 10'd200, P1, QR, 16'd0, 2'd3};
      tbl[2]  = '{0,0,0,1, 10'd150, 10'd200, P1, QR, 16'd0, 2'd3};
      tbl[3]  = '{0,0,0,1, 10'd300, 10'd200, P1, QR, 16'd1, 2'd3};
      tbl[4]  = '{0,0,0,1, 10'd320, 10'd200, P1, QR, 16'd1, 2'd3};
      tbl[5]  = '{0,0,0,1, 10'd100, 10'd200, P1, QR, 16'd1, 2'd3};
      tbl[6]  = '{0,0,0,1, 10'd300, 10'd200, P2, QR, 16'd3, 2'd3};
      tbl[7]  = '{0,0,0,0, 10'd100, 10'd200, P2, QR, 16'd3, 2'd3};
      tbl[8]  = '{0,0,0,1, 10'd100, 10'd200, P2, QR, 16'd3, 2'd3};
      tbl[9]  = '{0,0,1,1, 10'd300, 10'd200, P2, QP, 16'd3, 2'd3};
      tbl[10] = '{0,0,0,1, 10'd200, 10'd50,  P2, QP, 16'd3, 2'd3};
      tbl[11] = '{1,1,0,1, 10'd300, 10'd200, P2, QP, 16'd3, 2'd3};
      tbl[12] = '{0,0,1,0, 10'd100, 10'd200, P2, QR, 16'd3, 2'd3};
      tbl[13] = '{0,0,0,1, 10'd100, 10'd465, P2, QH, 16'd3, 2'd2};

      #12;
      chk_all(QI, 16'd0, 16'd0, 2'd3, 1'b0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;

      for (int i = 0; i < 14; i++)
         step(tbl[i].st, tbl[i].ak, tbl[i].pa, tbl[i].tk, tbl[i].xb,
              tbl[i].yb, tbl[i].xp, tbl[i].q, tbl[i].sc, 16'd0,
              tbl[i].lv, 1'b0);

      // HIT: colliding coordinates and a Pause pulse are ignored.
      for (int i = 1; i < 60; i++)
         step(0, 0, (i == 10), 1, 10'd200, 10'd50, P2,
              QH, 16'd3, 16'd0, 2'd2, 1'b0);
      step(0, 0, 0, 1, 10'd300, 10'd200, P2, QR, 16'd3, 16'd0, 2'd2, 1'b0);
      step(0, 0, 0, 1, 10'd300, 10'd200, P2, QR, 16'd3, 16'd0, 2'd2, 1'b0);
      step(0, 0, 0, 1, 10'd100, 10'd200, P2, QR, 16'd3, 16'd0, 2'd2, 1'b0);
      step(0, 0, 0, 1, 10'd300, 10'd200, P2, QR, 16'd5, 16'd0, 2'd2, 1'b0);
      respawn(16'd5, 16'd0, 2'd1, P2);
      step(0, 0, 0, 1, 10'd300, 10'd465, P2, QE, 16'd5, 16'd5, 2'd0, 1'b1);
      step(1, 0, 0, 1, 10'd300, 10'd200, P2, QE, 16'd5, 16'd5, 2'd0, 1'b1);
      step(1, 1, 0, 0, 10'd100, 10'd200, P2, QI, 16'd0, 16'd5, 2'd3, 1'b0);
      step(0, 0, 0, 0, 10'd100, 10'd200, P2, QI, 16'd0, 16'd5, 2'd3, 1'b0);

      // Second game ends at the same score: no new high.
      step(1, 0, 0, 0, 10'd100, 10'd200, P2, QR, 16'd0, 16'd5, 2'd3, 1'b0);
      step(0, 0, 0, 1, 10'd300, 10'd200, P2, QR, 16'd2, 16'd5, 2'd3, 1'b0);
      step(0, 0, 0, 1, 10'd100, 10'd200, P2, QR, 16'd2, 16'd5, 2'd3, 1'b0);
      step(0, 0, 0, 1, 10'd300, 10'd200, P2, QR, 16'd4, 16'd5, 2'd3, 1'b0);
      step(0, 0, 0, 1, 10'd100, 10'd200, P1, QR, 16'd4, 16'd5, 2'd3, 1'b0);
      step(0, 0, 0, 1, 10'd300, 10'd200, P1, QR, 16'd5, 16'd5, 2'd3, 1'b0);
      respawn(16'd5, 16'd5, 2'd2, P1);
      respawn(16'd5, 16'd5, 2'd1, P1);
      step(0, 0, 0, 1, 10'd300, 10'd465, P1, QE, 16'd5, 16'd5, 2'd0, 1'b0);
      step(0, 1, 0, 0, 10'd100, 10'd200, P1, QI, 16'd0, 16'd5, 2'd3, 1'b0);

      // Async reset in the middle of HIT, checked before the next edge.
      step(1, 0, 0, 0, 10'd100, 10'd200, P1, QR, 16'd0, 16'd5, 2'd3, 1'b0);
      step(0, 0, 0, 1, 10'd100, 10'd465, P1, QH, 16'd0, 16'd5, 2'd2, 1'b0);
      step(0, 0, 0, 1, 10'd100, 10'd200, P1, QH, 16'd0, 16'd5, 2'd2, 1'b0);
      #2;
      Reset = 1'b1;
      #1;
      chk_all(QI, 16'd0, 16'd0, 2'd3, 1'b0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;

      // Four pipes per pass; the 4-bit build must stick at 15.
      step(1, 0, 0, 0, 10'd100, 10'd200, P4, QR, 16'd0, 16'd0, 2'd3, 1'b0);
      chk("sat_start", 32'(s_score), 32'd0);
      for (int r = 1; r <= 5; r++) begin
         step(0, 0, 0, 1, 10'd300, 10'd200, P4, QR, 16'(4 * r), 16'd0,
              2'd3, 1'b0);
         chk("sat_score", 32'(s_score), (4 * r > 15) ? 32'd15 : 32'(4 * r));
         step(0, 0, 0, 1, 10'd100, 10'd200, P4, QR, 16'(4 * r), 16'd0,
              2'd3, 1'b0);
         chk("sat_hold", 32'(s_score), (4 * r > 15) ? 32'd15 : 32'(4 * r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/flappy_game_ctrl.md
Name: flappy_game_ctrl

Overview:
- Parametrised next-generation game controller for the Flappy Bird design.
- Tracks NUM_PIPES pipes, detects collisions and floor falls, and scores each pipe cleared.
- Adds lives with a respawn countdown, pause, a saturating score and a retained high score.
- Sits between the bird/pipe physics blocks (coordinate sources) and the display/score renderer.

Parameters:
- COORD_W, 10: width of every X/Y coordinate.
- NUM_PIPES, 4: number of pipe channels.
- BIRD_HALF, 10: bird half-size; the bird box is square.
- PIPE_HALF_W, 50: pipe half-width.
- GAP_H, 100: vertical gap height, measured from the pipe Y (gap top).
- FLOOR_Y, 470: floor line; reaching it counts as a fall.
- SCORE_W, 16: width of the score and high-score outputs.
- LIVES, 3: lives loaded at game start; must be at least 1.
- RESPAWN_TICKS, 60: Tick count spent in HIT before play resumes.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  begin a game; sampled in INIT only.
- Ack  in  1  acknowledge game over; sampled in END only.
- Pause  in  1  one-cycle pulse that toggles RUN/PAUSE.
- Tick  in  1  one-cycle frame strobe; game evaluation happens only on Tick.
- XBird  in  COORD_W  bird centre X.
- YBird  in  COORD_W  bird centre Y.
- XPipes  in  NUM_PIPES*COORD_W  pipe centre X values; pipe i occupies bits [i*COORD_W +: COORD_W].
- YPipes  in  NUM_PIPES*COORD_W  gap-top Y per pipe, same packing.
- q_I, q_Run, q_Pause, q_Hit, q_End  out  1 each  one-hot state flags.
- Score  out  SCORE_W  current score.
- HighScore  out  SCORE_W  best score since reset.
- LivesLeft  out  $clog2(LIVES+1)  remaining lives.
- NewHigh  out  1  set in END when the final score exceeded the previous HighScore.

Behaviour:
- Reset (asynchronous, any state, mid-game included): state=INIT; Score=0; HighScore=0; LivesLeft=LIVES; NewHigh=0; all passed flags=0; respawn counter=0.
- All outputs are registered. Every effect of a sampled input is visible on the cycle after it is sampled.
- Geometry: all comparisons use unsigned arithmetic widened to COORD_W+2 bits, so no add or subtract can wrap.
- Collision with pipe i requires X overlap: XBird+BIRD_HALF >= XPipe-PIPE_HALF_W and XBird-BIRD_HALF <= XPipe+PIPE_HALF_W.
- X overlap alone is not a collision if the bird is inside the gap: YBird-BIRD_HALF >= YPipe and YBird+BIRD_HALF <= YPipe+GAP_H.
- Collide = OR of the per-pipe collision terms.
- Fall = YBird+BIRD_HALF >= FLOOR_Y.
- Pipe i counts as passed when XBird-BIRD_HALF > XPipe+PIPE_HALF_W.
- Passed flag i is set on the first Tick the pipe is passed. It clears on a Tick where the pipe is not passed (pipe recycled to the right).
- Newly passed pipes in one Tick all add to Score together, so up to NUM_PIPES can score at once.
- Score saturates at 2^SCORE_W-1.
- INIT: Score=0, LivesLeft=LIVES, NewHigh=0. Start=1 moves to RUN; at that point passed flags load the current passed condition, so pipes already behind the bird never score.
- RUN, priority order:
  1. A Pause pulse on any cycle moves to PAUSE.
  2. Otherwise, on Tick with Collide|Fall: LivesLeft decrements; no score is added this Tick. If the new LivesLeft is 0, go to END; otherwise go to HIT with the counter loaded to RESPAWN_TICKS.
  3. Otherwise, on Tick: apply scoring.
- PAUSE: Tick is ignored and nothing changes. A Pause pulse returns to RUN. Start and Ack are ignored.
- HIT: the counter decrements on each Tick and collisions are ignored. When the counter reaches 0 on a Tick, passed flags re-load the current passed condition and the state returns to RUN. Pause is ignored in HIT.
- END entry, same cycle: if Score > HighScore, HighScore<=Score and NewHigh<=1. A score equal to HighScore does not set NewHigh.
- END: Ack=1 moves to INIT. Score and HighScore hold until then.
- Simultaneous Pause and Tick in RUN: Pause wins and the Tick is dropped.
- Start and Ack asserted together: only the input for the current state is honoured.

Test Plan:
- Reset, Start, then move the bird X past one pipe (XPipe=200) over several Ticks -> Score=1 exactly once, not re-incremented while the pipe stays behind.
- Two pipes at X=200 and 205 passed in one Tick -> Score increments by 2 in that single cycle.
- In RUN, YBird=465 on Tick (FLOOR_Y=470) -> LivesLeft 3->2, q_Hit=1. After 60 Ticks, q_Run=1. Collisions during HIT do not decrement LivesLeft.
- Three hits -> END with LivesLeft=0; Score 5 vs HighScore 0 -> HighScore=5, NewHigh=1. Next game ending at 5 -> NewHigh=0.
- Pause pulse with Tick in the same cycle -> q_Pause=1 and Score unchanged. Ticks with colliding coordinates during PAUSE change nothing. A second pulse returns to RUN.
- Reset asserted asynchronously mid-HIT -> outputs are the reset values immediately, without waiting for a Clk edge. Score saturation: preload near max via a reduced SCORE_W=4 build, then pass 20 pipes -> Score holds at 15.
